// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a ready/valid byte input.
// One byte is accepted in IDLE. It is sent as a start bit, 8 data bits
// (LSB first) and a stop bit. Each symbol lasts CLOCK_FREQ/BAUD_RATE cycles.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity symbol
// between the last data bit and the stop bit.
// data_in_ready and serial_out both come straight from flops.

module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);

   localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
   localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
   localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CYCLE =
      CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   state_t                         state, state_next;
   logic [CLOCK_COUNTER_WIDTH-1:0] cycle_cnt, cycle_cnt_next;
   logic [2:0]                     bit_cnt, bit_cnt_next;
   logic [7:0]                     shift_reg, shift_reg_next;
   logic                           serial_next;
   logic                           ready_next;
   logic                           fire;
   logic                           symbol_end;

   // A byte is accepted only while the registered ready is high, which is IDLE only.
   assign fire       = data_in_valid & data_in_ready;
   assign symbol_end = (cycle_cnt == LAST_CYCLE);

`ifdef UART_TX_PARITY_EN
   logic parity_bit;

   // Parity is taken from the byte as it is latched, so later changes to data_in have no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       parity_bit <= 1'b0;
      else if (fire) parity_bit <= ^data_in;
   end
`endif

   // State and registered outputs. Reset drops any frame in progress and forces the line high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cycle_cnt     <= '0;
         bit_cnt       <= 3'd0;
         shift_reg     <= 8'h00;
         serial_out    <= 1'b1;
         data_in_ready <= 1'b1;
      end else begin
         state         <= state_next;
         cycle_cnt     <= cycle_cnt_next;
         bit_cnt       <= bit_cnt_next;
         shift_reg     <= shift_reg_next;
         serial_out    <= serial_next;
         data_in_ready <= ready_next;
      end
   end

   // Next-state logic. Each next value for serial_out is the level of the
   // symbol that starts on the following cycle, so the line changes only at
   // symbol boundaries.
   always_comb begin
      state_next     = state;
      cycle_cnt_next = symbol_end ? '0 : cycle_cnt + 1'b1;
      bit_cnt_next   = bit_cnt;
      shift_reg_next = shift_reg;
      serial_next    = serial_out;
      ready_next     = data_in_ready;

      case (state)
         IDLE: begin
            cycle_cnt_next = '0;
            serial_next    = 1'b1;
            ready_next     = 1'b1;
            if (fire) begin
               state_next     = START;
               shift_reg_next = data_in;
               bit_cnt_next   = 3'd0;
               serial_next    = 1'b0;
               ready_next     = 1'b0;
            end
         end

         START: begin
            if (symbol_end) begin
               state_next  = DATA;
               serial_next = shift_reg[0];
            end
         end

         DATA: begin
            if (symbol_end) begin
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next  = PARITY;
                  serial_next = parity_bit;
`else
                  state_next  = STOP;
                  serial_next = 1'b1;
`endif
               end else begin
                  bit_cnt_next   = bit_cnt + 3'd1;
                  shift_reg_next = shift_reg >> 1;
                  serial_next    = shift_reg[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (symbol_end) begin
               state_next  = STOP;
               serial_next = 1'b1;
            end
         end
`endif

         STOP: begin
            if (symbol_end) begin
               state_next  = IDLE;
               serial_next = 1'b1;
               ready_next  = 1'b1;
            end
         end

         default: begin
            state_next     = IDLE;
            cycle_cnt_next = '0;
            serial_next    = 1'b1;
            ready_next     = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial transmit side of the CPU's UART. Converts bytes written by the CPU memory-mapped I/O path into 8N1 frames on `serial_out`.
- Peer of the CPU's serial receiver. In system benches, `serial_out` of this block loops into `serial_in` of the CPU so that software echo and BIOS output can be checked.
- Byte handoff uses a ready/valid handshake. Bit timing comes from a clock-divider counter.

Parameters:
- CLOCK_FREQ, 125_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits per second.
- SYMBOL_EDGE_TIME (derived localparam), CLOCK_FREQ/BAUD_RATE using integer division; this is the clock cycles per bit, written T below.
- CLOCK_COUNTER_WIDTH (derived localparam), $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  8  byte to transmit; sampled only on a fire cycle.
- data_in_valid  input  1  producer has a byte.
- data_in_ready  output  1  block can accept a byte.
- serial_out  output  1  UART line; idle level is high.

Behaviour:
- Reset, asynchronous: while rst=1, data_in_ready=1 and serial_out=1. The state machine goes to IDLE and the cycle counter and bit counter clear.
- Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit, and the aborted byte is never resent.
- States: IDLE -> START -> DATA -> STOP -> IDLE. With the optional feature, PARITY sits between DATA and STOP.
- Fire: a rising edge where data_in_valid and data_in_ready are both 1; this only happens in IDLE.
  - data_in is latched into the shift register on that edge.
  - data_in_ready=0 from the next cycle onward.
- Latency: serial_out goes low (start bit) on the first cycle after fire.
- Bit timing:
  - Each symbol (start, each data bit, parity, stop) drives serial_out for exactly T cycles.
  - The cycle counter runs 0..T-1 and wraps to 0 at each symbol boundary.
- DATA: 8 bits, LSB first. The bit counter runs 0..7, and the shift register shifts right at each symbol boundary.
- STOP: serial_out=1 for T cycles, then the block enters IDLE with data_in_ready=1.
- Back-to-back: if data_in_valid is held high, the next fire happens on the first IDLE cycle. That gives one extra high cycle between frames, so the minimum fire-to-fire spacing is 10T+1 cycles (11T+1 with parity).
- data_in and data_in_valid are ignored while data_in_ready=0. Changes to data_in mid-frame must not alter the transmitted bits.
- data_in_ready is a registered output and has no combinational dependence on data_in_valid.
- serial_out is a registered output with no glitches.
- data_in_valid asserted during reset is not accepted. The first fire can occur on the first clock edge after rst falls.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows the last data bit and drives even parity (XOR of the 8 data bits) for T cycles.
  - Frame is 11 symbols.
  - Parity is computed from the latched byte, not the live data_in.
- Undefined:
  - No PARITY state; frames are 8N1, 10 symbols.
  - No parity logic is synthesized.

Test Plan (CLOCK_FREQ=50_000_000, BAUD_RATE=115_200, so T=434):
- Reset: hold rst=1 for 10 cycles, then release -> serial_out=1 and data_in_ready=1 during and after reset. The line stays high with no valid.
- Single byte: send 0x55 -> ready drops the cycle after fire.
  - Sampling at mid-symbol (fire+1+217+434k) gives 0,1,0,1,0,1,0,1,0,1, i.e. start, LSB-first data, stop.
  - Ready returns 1 at fire+1+4340.
- Back-to-back: hold valid with 0xA5 then 0x3C -> both frames decode correctly, and the second fire occurs exactly 4341 cycles after the first.
- Mid-frame data change: fire 0x0F, then set data_in=0xF0 with valid=1 during DATA -> the line carries 0x0F, and 0xF0 is accepted only on the next IDLE cycle.
- Reset mid-frame: assert rst asynchronously (not on a clock edge) during bit 3 of 0x00 -> serial_out=1 within the same cycle and ready=1. After release, a fresh 0x81 transmits cleanly.
- With UART_TX_PARITY_EN: send 0x07 -> parity symbol=1. Send 0x03 -> parity=0. The frame is 11 symbols, and ready returns at fire+1+4774.
